// File: rtl/cal_avg_pkg.sv
// Shared constants for the calibration-average packetizer: header magic,
// FSM encoding and default parameters.
package cal_avg_pkg;

   localparam logic [15:0] HDR_MAGIC = 16'hCA1B;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_PKT_LEN   = 64;
   localparam int DEF_RD_LAT    = 2;
   localparam int DEF_BUF_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_TAIL    = 2'd3
   } state_t;

   function automatic logic [31:0] hdr_word(input logic [15:0] seq);
      return {HDR_MAGIC, seq};
   endfunction

endpackage

// File: rtl/cal_avg_skid_fifo.sv
// Small in-order output buffer holding FIFO words between return and transfer;
// head is presented from registers so it stays stable while stalled.
module cal_avg_skid_fifo
   import cal_avg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_BUF_DEPTH,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OW   = $clog2(DEPTH + 1)
) (
   input  logic             gclk,
   input  logic             grst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic [OW-1:0]    occ
);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic                        do_push, do_pop;

   assign empty   = (occ == '0);
   assign full    = (occ == OW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge gclk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         occ <= occ + OW'(do_push) - OW'(do_pop);
      end
   end

endmodule

// File: rtl/cal_avg_packetizer.sv
// Packetizes PKT_LEN averaged words from a fixed-latency FIFO into
// header / payload / checksum-tail frames on a valid/ready stream.
module cal_avg_packetizer
   import cal_avg_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int PKT_LEN   = DEF_PKT_LEN,
   parameter int RD_LAT    = DEF_RD_LAT,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic             ENABLE,
   input  logic [7:0]       FIFO_WORDS,
   output logic             FIFO_RE,
   input  logic [WIDTH-1:0] FIFO_RDATA,
   output logic [WIDTH-1:0] M_DATA,
   output logic             M_VALID,
   input  logic             M_READY,
   output logic             M_SOP,
   output logic             M_EOP,
   output logic             BUSY,
   output logic [15:0]      SEQ
);

   localparam int OCC_W = $clog2(BUF_DEPTH + 1);
   localparam int IFL_W = $clog2(RD_LAT + 1) + 1;

   state_t            state;
   logic [15:0]       seq_q;
   logic [WIDTH-1:0]  csum;
   logic [7:0]        issued, sent;
   logic [RD_LAT-1:0] rd_pipe;
   logic [IFL_W-1:0]  in_flight;
   logic [OCC_W-1:0]  occ;
   logic [WIDTH-1:0]  head;
   logic              buf_empty, buf_full;
   logic              rd_valid, fifo_re_c, xfer, pop;

   assign rd_valid = rd_pipe[RD_LAT-1];
   assign xfer     = M_VALID && M_READY;
   assign pop      = xfer && (state == ST_PAYLOAD);

   // Credit check counts words already requested, so the buffer can never overflow.
   assign fifo_re_c = ((state == ST_HEADER) || (state == ST_PAYLOAD)) &&
                      (issued < 8'(PKT_LEN)) &&
                      ((32'(occ) + 32'(in_flight)) < 32'(BUF_DEPTH));

   assign FIFO_RE = fifo_re_c;
   assign BUSY    = (state != ST_IDLE);
   assign SEQ     = seq_q;

   cal_avg_skid_fifo #(.WIDTH(WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
      .gclk      (CLOCK),
      .grst_n    (RESET_N),
      .push      (rd_valid),
      .push_data (FIFO_RDATA),
      .pop       (pop),
      .head      (head),
      .empty     (buf_empty),
      .full      (buf_full),
      .occ       (occ)
   );

   always_comb begin
      M_DATA  = '0;
      M_VALID = 1'b0;
      M_SOP   = 1'b0;
      M_EOP   = 1'b0;
      case (state)
         ST_HEADER: begin
            M_DATA  = WIDTH'(hdr_word(seq_q));
            M_VALID = 1'b1;
            M_SOP   = 1'b1;
         end
         ST_PAYLOAD: begin
            M_DATA  = head;
            M_VALID = !buf_empty;
         end
         ST_TAIL: begin
            M_DATA  = csum;
            M_VALID = 1'b1;
            M_EOP   = 1'b1;
         end
         default: ;
      endcase
   end

   // Read-return tracking; cleared on reset so abandoned reads are ignored.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_pipe   <= '0;
         in_flight <= '0;
      end else begin
         rd_pipe[0] <= fifo_re_c;
         for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         in_flight <= in_flight + IFL_W'(fifo_re_c) - IFL_W'(rd_valid);
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= ST_IDLE;
         seq_q  <= '0;
         csum   <= '0;
         issued <= '0;
         sent   <= '0;
      end else begin
         if (fifo_re_c) issued <= issued + 8'd1;
         case (state)
            ST_IDLE: begin
               issued <= '0;
               sent   <= '0;
               csum   <= '0;
               if (ENABLE && (FIFO_WORDS >= 8'(PKT_LEN))) state <= ST_HEADER;
            end
            ST_HEADER: begin
               if (xfer) state <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               if (pop) begin
                  csum <= csum + head;
                  sent <= sent + 8'd1;
                  if (sent == 8'(PKT_LEN - 1)) state <= ST_TAIL;
               end
            end
            ST_TAIL: begin
               if (xfer) begin
                  seq_q <= seq_q + 16'd1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cal_avg_packetizer.sv
// Scoreboard bench for cal_avg_packetizer with a fixed-latency FIFO model.
module tb_cal_avg_packetizer;

   localparam int PKT_LEN   = 4;
   localparam int RD_LAT    = 2;
   localparam int BUF_DEPTH = 4;

   logic        CLOCK = 1'b0;
   logic        RESET_N;
   logic        ENABLE;
   logic [7:0]  FIFO_WORDS = 8'd0;
   logic        FIFO_RE;
   logic [31:0] FIFO_RDATA = 32'd0;
   logic [31:0] M_DATA;
   logic        M_VALID;
   logic        M_READY;
   logic        M_SOP, M_EOP, BUSY;
   logic [15:0] SEQ;

   cal_avg_packetizer #(.WIDTH(32), .PKT_LEN(PKT_LEN), .RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .FIFO_WORDS(FIFO_WORDS),
      .FIFO_RE(FIFO_RE), .FIFO_RDATA(FIFO_RDATA), .M_DATA(M_DATA), .M_VALID(M_VALID),
      .M_READY(M_READY), .M_SOP(M_SOP), .M_EOP(M_EOP), .BUSY(BUSY), .SEQ(SEQ)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct packed {
      logic [31:0] d;
      logic        sop;
      logic        eop;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] src_q[$];
   logic [31:0] dpipe [RD_LAT];
   int          checks = 0, errors = 0;
   int          re_cnt = 0, busy_cyc = 0, max_occ = 0;
   logic        rnd_rdy = 1'b0;
   logic        re_s;

   // FIFO model: a read issued in cycle c returns data during cycle c+RD_LAT.
   always @(posedge CLOCK) begin
      re_s = FIFO_RE;
      #1;
      for (int k = RD_LAT - 1; k > 0; k--) dpipe[k] = dpipe[k-1];
      dpipe[0] = (re_s && src_q.size() > 0) ? src_q.pop_front() : 32'hDEADBEEF;
      if (re_s) re_cnt++;
      FIFO_RDATA = dpipe[RD_LAT-1];
   end

   always @(negedge CLOCK) FIFO_WORDS = (src_q.size() > 255) ? 8'd255 : 8'(src_q.size());

   always @(posedge CLOCK) begin
      #1;
      M_READY = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: pop and compare every transfer; check hold-stable under stall.
   logic        prev_v = 1'b0, prev_r = 1'b0, prev_sop, prev_eop;
   logic [31:0] prev_d;
   beat_t       e;
   always @(negedge CLOCK) begin
      if (RESET_N === 1'b1) begin
         if (BUSY) busy_cyc++;
         if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
         if (prev_v && !prev_r) begin
            checks++;
            if (!M_VALID || M_DATA !== prev_d || M_SOP !== prev_sop || M_EOP !== prev_eop) begin
               errors++;
               $display("FAIL stall_hold: got v=%b d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                        M_VALID, M_DATA, M_SOP, M_EOP, prev_d, prev_sop, prev_eop);
            end
         end
         if (M_VALID && M_READY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got d=%h sop=%b eop=%b expected no beat", M_DATA, M_SOP, M_EOP);
            end else begin
               e = exp_q.pop_front();
               if (M_DATA !== e.d || M_SOP !== e.sop || M_EOP !== e.eop) begin
                  errors++;
                  $display("FAIL stream_beat: got d=%h sop=%b eop=%b expected d=%h sop=%b eop=%b",
                           M_DATA, M_SOP, M_EOP, e.d, e.sop, e.eop);
               end
            end
         end
         prev_v = M_VALID; prev_r = M_READY; prev_d = M_DATA; prev_sop = M_SOP; prev_eop = M_EOP;
      end else begin
         prev_v = 1'b0;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input logic [15:0] seq, input logic [31:0] w0, w1, w2, w3, tail);
      exp_q.push_back('{d: {16'hCA1B, seq}, sop: 1'b1, eop: 1'b0});
      exp_q.push_back('{d: w0, sop: 1'b0, eop: 1'b0});
      exp_q.push_back('{d: w1, sop: 1'b0, eop: 1'b0});
      exp_q.push_back('{d: w2, sop: 1'b0, eop: 1'b0});
      exp_q.push_back('{d: w3, sop: 1'b0, eop: 1'b0});
      exp_q.push_back('{d: tail, sop: 1'b0, eop: 1'b1});
   endtask

   task automatic load(input logic [31:0] w0, w1, w2, w3);
      src_q.push_back(w0); src_q.push_back(w1); src_q.push_back(w2); src_q.push_back(w3);
   endtask

   task automatic wait_done(input string name, input int max);
      int n = 0;
      while ((exp_q.size() != 0 || BUSY === 1'b1) && n < max) begin
         tick();
         n++;
      end
      if (n >= max) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, exp_q.size());
      end
   endtask

   initial begin
      for (int k = 0; k < RD_LAT; k++) dpipe[k] = 32'd0;
      RESET_N = 1'b0;
      ENABLE  = 1'b0;
      tick(3);
      chk("rst_m_valid", 32'(M_VALID), 0);
      chk("rst_fifo_re", 32'(FIFO_RE), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_m_data", M_DATA, 0);
      chk("rst_sop_eop", {30'd0, M_SOP, M_EOP}, 0);
      chk("rst_seq", 32'(SEQ), 0);
      RESET_N = 1'b1;
      tick(2);

      // Too few words: nothing starts.
      ENABLE = 1'b1;
      src_q.push_back(32'd1); src_q.push_back(32'd2); src_q.push_back(32'd3);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("short_fifo_re", 32'(FIFO_RE), 0);
         chk("short_m_valid", 32'(M_VALID), 0);
         chk("short_busy", 32'(BUSY), 0);
      end

      // Basic packet and latency.
      push_pkt(16'h0000, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A);
      re_cnt = 0; busy_cyc = 0;
      src_q.push_back(32'd4);
      wait_done("basic", 100);
      chk("basic_busy_cycles", 32'(busy_cyc), 32'(PKT_LEN + 2 + RD_LAT));
      chk("basic_re_count", 32'(re_cnt), 4);
      chk("basic_seq", 32'(SEQ), 1);

      // Checksum wrap-around.
      push_pkt(16'h0001, 32'hFFFFFFFF, 32'h00000002, 32'd0, 32'd0, 32'h00000001);
      load(32'hFFFFFFFF, 32'h00000002, 32'd0, 32'd0);
      wait_done("wrap_sum", 100);
      chk("wrap_seq", 32'(SEQ), 2);

      // Random backpressure.
      rnd_rdy = 1'b1; re_cnt = 0; max_occ = 0;
      push_pkt(16'h0002, 32'h10, 32'h20, 32'h30, 32'h40, 32'hA0);
      load(32'h10, 32'h20, 32'h30, 32'h40);
      wait_done("rand_ready", 300);
      rnd_rdy = 1'b0;
      tick(2);
      chk("rand_re_count", 32'(re_cnt), 4);
      chk("rand_max_occ_le_depth", 32'(max_occ <= BUF_DEPTH), 1);
      chk("rand_seq", 32'(SEQ), 3);

      // ENABLE dropped mid-packet: current packet completes, next waits.
      push_pkt(16'h0003, 32'd5, 32'd6, 32'd7, 32'd8, 32'h1A);
      load(32'd5, 32'd6, 32'd7, 32'd8);
      load(32'd9, 32'd10, 32'd11, 32'd12);
      begin
         int n = 0;
         while (BUSY !== 1'b1 && n < 20) begin tick(); n++; end
         chk("en_drop_started", 32'(BUSY), 1);
      end
      ENABLE = 1'b0;
      wait_done("en_drop", 100);
      tick(5);
      chk("en_drop_idle", 32'(BUSY), 0);
      chk("en_drop_words_left", 32'(src_q.size()), 4);
      push_pkt(16'h0004, 32'd9, 32'd10, 32'd11, 32'd12, 32'h2A);
      ENABLE = 1'b1;
      wait_done("en_resume", 100);
      chk("en_resume_seq", 32'(SEQ), 5);

      // SEQ wrap with back-to-back packets.
      force dut.seq_q = 16'hFFFF;
      tick();
      release dut.seq_q;
      tick();
      chk("seq_forced", 32'(SEQ), 32'hFFFF);
      push_pkt(16'hFFFF, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0A);
      push_pkt(16'h0000, 32'd5, 32'd6, 32'd7, 32'd8, 32'h1A);
      load(32'd1, 32'd2, 32'd3, 32'd4);
      load(32'd5, 32'd6, 32'd7, 32'd8);
      wait_done("seq_wrap", 200);
      chk("seq_wrap_after", 32'(SEQ), 1);

      // Reset during payload word 2.
      push_pkt(16'h0001, 32'h100, 32'h200, 32'h300, 32'h400, 32'hA00);
      load(32'h100, 32'h200, 32'h300, 32'h400);
      begin
         int n = 0;
         while (exp_q.size() > 4 && n < 50) begin tick(); n++; end
         chk("rst_mid_reached_payload", 32'(exp_q.size()), 4);
      end
      RESET_N = 1'b0;
      #1;
      chk("rst_mid_m_valid", 32'(M_VALID), 0);
      chk("rst_mid_fifo_re", 32'(FIFO_RE), 0);
      chk("rst_mid_busy", 32'(BUSY), 0);
      chk("rst_mid_m_data", M_DATA, 0);
      chk("rst_mid_sop_eop", {30'd0, M_SOP, M_EOP}, 0);
      chk("rst_mid_seq", 32'(SEQ), 0);
      exp_q.delete();
      tick(3);
      src_q.delete();
      RESET_N = 1'b1;
      tick();
      re_cnt = 0;
      push_pkt(16'h0000, 32'd5, 32'd6, 32'd7, 32'd8, 32'h1A);
      load(32'd5, 32'd6, 32'd7, 32'd8);
      wait_done("post_rst", 100);
      chk("post_rst_re_count", 32'(re_cnt), 4);
      chk("post_rst_seq", 32'(SEQ), 1);

      tick(3);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
